// File: rtl/serial_add_pkg.sv
// Shared encodings and defaults for the bit-serial add/subtract sequencer.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/FULL_ADDER.sv
// One-bit full-adder cell, the only arithmetic element of the serial datapath.
module FULL_ADDER (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/shift_reg_pl.sv
// Parallel-load right-shift register with serial input, sync clear and async active-low clear.
module shift_reg_pl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Clear beats load beats shift; new bits enter at the MSB.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {ser_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract: one full-adder cell stepped LSB first over WIDTH cycles,
// result presented under a DONE/ACK handshake.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             OVF
);

  localparam int CW = $clog2(WIDTH);

  state_e          state_q, state_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   count_q, count_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            load_ops;
  logic            shift_en;
  logic            clr_all;
  logic            last_bit;
  logic            fa_sum;
  logic            fa_co;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] b_load;
  logic             unused_op_bits;

  // Subtraction is A + ~B + 1: invert B at load and seed the carry with SUB.
  assign b_load   = SUB ? ~B : B;
  assign last_bit = (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    carry_d  = carry_q;
    count_d  = count_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    load_ops = 1'b0;
    shift_en = 1'b0;
    clr_all  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          load_ops = 1'b1;
          carry_d  = SUB;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        shift_en = 1'b1;
        carry_d  = fa_co;
        count_d  = count_q + 1'b1;
        if (last_bit) begin
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ACK) begin
          if (START) begin
            load_ops = 1'b1;
            carry_d  = SUB;
            count_d  = '0;
            state_d  = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        // Unreachable encoding: drop everything back to the reset picture.
        clr_all = 1'b1;
        carry_d = 1'b0;
        count_d = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      count_q <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      count_q <= count_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  shift_reg_pl #(.WIDTH(WIDTH)) u_sreg_a (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (clr_all),
    .load     (load_ops),
    .shift    (shift_en),
    .load_val (A),
    .ser_in   (1'b0),
    .q        (sa_q)
  );

  shift_reg_pl #(.WIDTH(WIDTH)) u_sreg_b (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (clr_all),
    .load     (load_ops),
    .shift    (shift_en),
    .load_val (b_load),
    .ser_in   (1'b0),
    .q        (sb_q)
  );

  // The result register is never loaded; WIDTH shifts fully replace its contents.
  shift_reg_pl #(.WIDTH(WIDTH)) u_sreg_res (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (clr_all),
    .load     (1'b0),
    .shift    (shift_en),
    .load_val ('0),
    .ser_in   (fa_sum),
    .q        (res_q)
  );

  FULL_ADDER u_fa (
    .A  (sa_q[0]),
    .B  (sb_q[0]),
    .CI (carry_q),
    .S  (fa_sum),
    .CO (fa_co)
  );

  // Only the LSB of each operand register feeds the adder.
  assign unused_op_bits = ^{sa_q[WIDTH-1:1], sb_q[WIDTH-1:1]};

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = res_q;
  assign COUT   = cout_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed scoreboard bench for serial_add_sequencer at WIDTH=8.
module tb_serial_add_sequencer;

  typedef struct packed {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       SUB;
  logic [7:0] A;
  logic [7:0] B;
  logic       ACK;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;
  logic       COUT;
  logic       OVF;

  int   total;
  int   bad;
  exp_t sb[$];
  exp_t lastExp;

  serial_add_sequencer #(.WIDTH(8)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .SUB    (SUB),
    .A      (A),
    .B      (B),
    .ACK    (ACK),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT),
    .COUT   (COUT),
    .OVF    (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference arithmetic written with ordinary wide addition.
  function automatic exp_t model(input logic sub, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    exp_t e;
    if (sub) begin
      full  = {1'b0, a} + {1'b0, ~b} + 9'd1;
      e.ovf = (a[7] != b[7]) && (full[7] != a[7]);
    end else begin
      full  = {1'b0, a} + {1'b0, b};
      e.ovf = (a[7] == b[7]) && (full[7] != a[7]);
    end
    e.res  = full[7:0];
    e.cout = full[8];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a START pulse and leaves the bench at the first negedge after the sampling edge.
  task automatic applyStimulus(input logic sub, input logic [7:0] a, input logic [7:0] b,
                               input bit holdStart);
    @(negedge CLK);
    SUB   = sub;
    A     = a;
    B     = b;
    START = 1'b1;
    ACK   = 1'b0;
    sb.push_back(model(sub, a, b));
    @(negedge CLK);
    if (holdStart) begin
      A   = ~a;
      B   = ~b;
      SUB = ~sub;
    end else begin
      START = 1'b0;
    end
  endtask

  task automatic waitDone();
    int cycles;
    int busyCnt;
    cycles  = 1;
    busyCnt = 0;
    while (DONE !== 1'b1 && cycles < 30) begin
      if (BUSY === 1'b1) busyCnt++;
      @(negedge CLK);
      cycles++;
    end
    checkOutput("latency", cycles, 9);
    checkOutput("busy_cycles", busyCnt, 8);
  endtask

  task automatic checkResult();
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      lastExp = sb.pop_front();
      checkOutput("result", RESULT, lastExp.res);
      checkOutput("cout", COUT, lastExp.cout);
      checkOutput("ovf", OVF, lastExp.ovf);
      checkOutput("busy_in_done", BUSY, 0);
    end
  endtask

  task automatic ackResult();
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
    checkOutput("done_after_ack", DONE, 0);
    checkOutput("busy_after_ack", BUSY, 0);
    checkOutput("result_kept", RESULT, lastExp.res);
    checkOutput("cout_kept", COUT, lastExp.cout);
    checkOutput("ovf_kept", OVF, lastExp.ovf);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, BUSY, 0);
    checkOutput({tag, "_done"}, DONE, 0);
    checkOutput({tag, "_result"}, RESULT, 0);
    checkOutput({tag, "_cout"}, COUT, 0);
    checkOutput({tag, "_ovf"}, OVF, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST_N = 1'b1;
    START = 1'b0;
    SUB   = 1'b0;
    A     = '0;
    B     = '0;
    ACK   = 1'b0;
    #1 RST_N = 1'b0;
    #2 checkResetState("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    $display("[TB] basic add");
    applyStimulus(1'b0, 8'h35, 8'h4A, 1'b0);
    waitDone();
    checkResult();
    ackResult();

    $display("[TB] add carry and overflow");
    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0);
    waitDone();
    checkResult();
    ackResult();
    applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0);
    waitDone();
    checkResult();
    ackResult();

    $display("[TB] subtract");
    applyStimulus(1'b1, 8'h05, 8'h07, 1'b0);
    waitDone();
    checkResult();
    ackResult();
    applyStimulus(1'b1, 8'h80, 8'h01, 1'b0);
    waitDone();
    checkResult();
    ackResult();

    $display("[TB] START held during RUN, ACK withheld");
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b1);
    waitDone();
    checkResult();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("hold_done", DONE, 1);
      checkOutput("hold_result", RESULT, lastExp.res);
    end

    $display("[TB] back-to-back via ACK with START");
    ACK   = 1'b1;
    START = 1'b1;
    SUB   = 1'b0;
    A     = 8'h10;
    B     = 8'h20;
    sb.push_back(model(1'b0, 8'h10, 8'h20));
    @(negedge CLK);
    ACK   = 1'b0;
    START = 1'b0;
    checkOutput("b2b_busy", BUSY, 1);
    checkOutput("b2b_done", DONE, 0);
    waitDone();
    checkResult();
    ackResult();

    applyStimulus(1'b0, 8'hC0, 8'h80, 1'b0);
    waitDone();
    checkResult();
    ackResult();

    $display("[TB] async reset mid-RUN");
    applyStimulus(1'b0, 8'h5A, 8'hA5, 1'b0);
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 checkResetState("async_reset");
    sb.delete();
    @(negedge CLK);
    checkResetState("held_reset");
    RST_N = 1'b1;
    applyStimulus(1'b0, 8'h01, 8'h01, 1'b0);
    waitDone();
    checkResult();
    ackResult();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Multi-cycle, bit-serial add/subtract unit for area-constrained ALU paths.
- Sequences a single one-bit full-adder cell over WIDTH cycles, LSB first, with a registered carry.
- Captures operands on a START request and presents RESULT, COUT and OVF under a DONE/ACK handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- CLK     input   1      rising-edge clock.
- RST_N   input   1      asynchronous active-low reset.
- START   input   1      request; sampled only in IDLE, or in DONE together with ACK.
- SUB     input   1      0 = A+B, 1 = A-B; sampled with START.
- A       input   WIDTH  operand A; sampled with START.
- B       input   WIDTH  operand B; sampled with START.
- ACK     input   1      consumer accepts the result; meaningful only while DONE=1.
- BUSY    output  1      high in RUN.
- DONE    output  1      high in DONE; RESULT/COUT/OVF are valid and stable while high.
- RESULT  output  WIDTH  sum/difference, two's complement.
- COUT    output  1      carry out of the MSB; for SUB, 1 = no borrow.
- OVF     output  1      signed overflow.

Behaviour:
- Reset: async on RST_N=0, effective immediately, including mid-RUN.
  - State -> IDLE.
  - BUSY=0, DONE=0, RESULT=0, COUT=0, OVF=0.
  - Internal carry and bit counter cleared; operand shift registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, START=1 at an edge:
  - Load shift-A <= A; shift-B <= SUB ? ~B : B; carry <= SUB; count <= 0.
  - Go to RUN.
  - START=0 in IDLE: stay in IDLE.
- RUN, every edge:
  - Full-adder inputs: shift-A[0], shift-B[0], carry.
  - Shift-A and shift-B shift right by one.
  - Result shift register shifts right, taking SUM into bit WIDTH-1.
  - carry <= full-adder COUT; count <= count+1.
  - On the edge where count == WIDTH-1:
    - COUT <= full-adder COUT.
    - OVF <= carry XOR full-adder COUT, i.e. carry-in to the MSB XOR carry-out of the MSB.
    - Go to DONE.
  - START is ignored in RUN.
- Latency: DONE rises after the (WIDTH+1)th rising edge, counting the START-sampling edge as the 1st.
  - Throughput: one operation per WIDTH+1 cycles when back-to-back.
- DONE:
  - Outputs are held until ACK=1.
  - ACK=1, START=0: go to IDLE; RESULT/COUT/OVF keep their values until the next load.
  - ACK=1, START=1: load the new operands exactly as in IDLE and go directly to RUN; DONE drops after that edge.
  - ACK=0: stay in DONE, whatever START is.
- RESULT may change during RUN. Consumers must qualify it with DONE.
- Arithmetic is modulo 2^WIDTH. SUB is true two's-complement subtraction: A + ~B + 1.
- Illegal state encoding: recover to IDLE on the next edge, with outputs at reset values.

Decomposition:
- Shared package (serial_add_pkg):
  - State encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH constant.
- Sub-modules:
  - The one-bit adder is the existing FULL_ADDER cell, instantiated once. Do not write a behavioural `+`.
  - One natural sub-module: shift_reg_pl, a WIDTH-bit parallel-load, right-shift register with serial input and async active-low clear. Instantiate it three times (A, B, result).

Test Plan (WIDTH=8):
1. A=8'h35, B=8'h4A, SUB=0, pulse START -> DONE=1 after the 9th edge; RESULT=8'h7F, COUT=0, OVF=0; BUSY=1 for exactly 8 cycles.
2. A=8'hFF, B=8'h01, SUB=0 -> RESULT=8'h00, COUT=1, OVF=0. Then A=8'h7F, B=8'h01 -> RESULT=8'h80, COUT=0, OVF=1.
3. SUB=1, A=8'h05, B=8'h07 -> RESULT=8'hFE, COUT=0, OVF=0. Then A=8'h80, B=8'h01 -> RESULT=8'h7F, COUT=1, OVF=1.
4. START held high during RUN with different A/B -> ignored; result is that of the original operands. Hold ACK=0 for 5 cycles -> DONE and RESULT stable throughout.
5. In DONE, ACK=1 and START=1 with A=8'h10, B=8'h20 -> no IDLE cycle; BUSY the next cycle; RESULT=8'h30 eight edges later.
6. RST_N=0 asynchronously at RUN cycle 4 -> BUSY/DONE/RESULT/COUT/OVF=0 without waiting for a clock edge. Release reset, then START with 8'h01+8'h01 -> RESULT=8'h02 with normal latency.
